instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset; SHALL be word-aligned.
REQ-002 Parameter: FIFO_DEPTH, 2, fetch buffer entries; fixed at 2.
REQ-003 Port: clk  in  1  single clock, all state on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: imem_addr  out  32  byte address to instruction ROM (ROM indexes addr[31:2], combinational read).
REQ-006 Port: imem_rdata  in  32  instruction word returned same cycle for imem_addr.
REQ-007 Port: redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-008 Port: redirect_target  in  32  new PC for redirect.
REQ-009 Port: instr_valid  out  1  head FIFO entry valid to decode.
REQ-010 Port: instr_ready  in  1  decode accepts head entry.
REQ-011 Port: instr_out  out  32  head instruction word.
REQ-012 Port: pc_out  out  32  PC of head instruction.
REQ-013 Port: fetch_err  out  1  sticky misaligned-redirect error.

Function
REQ-014 imem_addr SHALL equal the PC register at all times (combinational).
REQ-015 States: RUN, HALT; reset enters RUN.
REQ-016 Pop SHALL occur when instr_valid && instr_ready; FIFO advances at the edge.
REQ-017 In RUN, push SHALL occur when !redirect_valid && (count<2 || pop); push stores {PC, imem_rdata} and PC <= PC+4.
REQ-018 instr_valid SHALL be (count!=0); instr_out/pc_out SHALL come from the head entry, stable while instr_valid && !instr_ready.
REQ-019 Latency: entry pushed at edge N SHALL be visible on instr_valid in cycle N+1 if FIFO empty.
REQ-020 Simultaneous push and pop with count==2 SHALL keep count 2; with count==1 keep count 1.
REQ-021 Redirect (RUN, target[1:0]==0): FIFO flushed (count 0), PC <= redirect_target, no push that cycle; redirect overrides push and pop.
REQ-022 After redirect at cycle N: imem_addr==target in N+1, instr_valid with pc_out==target in N+2.
REQ-023 Redirect with target[1:0]!=0: FIFO flushed, PC held, state -> HALT, fetch_err <= 1.
REQ-024 In HALT: no push, redirect ignored, instr_valid 0, fetch_err stays 1 until reset.
REQ-025 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-026 Full FIFO with instr_ready=0: no push, PC held, imem_addr unchanged.

Reset
REQ-027 reset asserted SHALL immediately force: PC=RESET_PC, count 0, FIFO storage 0, state RUN, fetch_err 0.
REQ-028 Reset values: imem_addr=RESET_PC, instr_valid=0, instr_out=0, pc_out=0, fetch_err=0.
REQ-029 Reset mid-operation SHALL discard all buffered entries; first push after release at first rising edge with reset low.

Structure
REQ-030 Package rv_fetch_pkg SHALL hold fetch_state_t {FETCH_RUN, FETCH_HALT}, FETCH_FIFO_DEPTH=2, INSTR_BYTES=4.
REQ-031 Sub-module fetch_fifo2 (2-entry, 64-bit {pc,instr}, push/pop/flush, count) SHALL implement buffering; instr_fetch holds PC, FSM, handshake.

Verification
REQ-032 Reset release, ROM words 0..3 loaded, instr_ready=1 -> pc_out 0,4,8,C on consecutive cycles from cycle 1, instr_out matches ROM.
REQ-033 instr_ready=0 for 5 cycles -> count reaches 2, imem_addr holds 8, pc_out holds 0; ready=1 -> 0,4,8 in order, no loss/duplication.
REQ-034 redirect_valid=1, target=0x1C at cycle N with FIFO full -> instr_valid 0 in N+1, pc_out=0x1C, instr_out=ROM[7] in N+2.
REQ-035 redirect target 0x1E -> fetch_err=1 next cycle, instr_valid 0, later aligned redirects ignored; reset clears fetch_err.
REQ-036 RESET_PC=32'hFFFF_FFFC, ready=1 -> pc_out FFFF_FFFC then 0000_0000.
REQ-037 reset asserted asynchronously mid-cycle with FIFO full -> instr_valid 0 and imem_addr=RESET_PC before next clock edge.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The fetch buffer carries {pc, instr} pairs through a fixed two-entry FIFO.
package rv_fetch_pkg;

    typedef enum logic [0:0] {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

    localparam int FETCH_FIFO_DEPTH = 2;
    localparam int INSTR_BYTES      = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry fetch buffer with the head always held in entry0.
// Flush overrides push and pop.
module fetch_fifo2
    import rv_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    localparam logic [1:0] DEPTH_C = 2'(FETCH_FIFO_DEPTH);

    fetch_entry_t entry0_r;
    fetch_entry_t entry1_r;
    fetch_entry_t entry0_next_s;
    fetch_entry_t entry1_next_s;
    logic [1:0]   count_r;
    logic [1:0]   count_next_s;
    logic         pop_ok_s;
    logic         push_ok_s;

    // Next-state of storage and occupancy; the head slot shifts on pop.
    always_comb begin
        entry0_next_s = entry0_r;
        entry1_next_s = entry1_r;
        count_next_s  = count_r;
        pop_ok_s      = pop && (count_r != 2'd0);
        push_ok_s     = push && ((count_r < DEPTH_C) || pop_ok_s);
        if (flush) begin
            count_next_s = 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        entry0_next_s = din;
                    end else begin
                        entry1_next_s = din;
                    end
                    count_next_s = count_r + 2'd1;
                end
                2'b01: begin
                    entry0_next_s = entry1_r;
                    count_next_s  = count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        entry0_next_s = din;
                    end else begin
                        entry0_next_s = entry1_r;
                        entry1_next_s = din;
                    end
                end
                default: begin
                    count_next_s = count_r;
                end
            endcase
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry0_r <= '0;
            entry1_r <= '0;
            count_r  <= 2'd0;
        end else begin
            entry0_r <= entry0_next_s;
            entry1_r <= entry1_next_s;
            count_r  <= count_next_s;
        end
    end

    assign head  = entry0_r;
    assign count = count_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, RUN/HALT control and decode handshake
// in front of a two-entry {pc, instr} buffer.
module instr_fetch
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        fetch_err
);

    localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

    fetch_state_t state_r;
    fetch_state_t state_next_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_next_s;
    logic         err_r;
    logic         err_next_s;
    logic         push_s;
    logic         pop_s;
    logic         flush_s;
    fetch_entry_t din_s;
    fetch_entry_t head_s;
    logic [1:0]   count_s;

    // Fetch control: redirect beats push/pop; a misaligned target halts fetch.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        err_next_s   = err_r;
        push_s       = 1'b0;
        flush_s      = 1'b0;
        pop_s        = (count_s != 2'd0) && instr_ready;
        din_s        = '{pc: pc_r, instr: imem_rdata};
        case (state_r)
            FETCH_RUN: begin
                if (redirect_valid) begin
                    flush_s = 1'b1;
                    if (redirect_target[1:0] == 2'b00) begin
                        pc_next_s = redirect_target;
                    end else begin
                        state_next_s = FETCH_HALT;
                        err_next_s   = 1'b1;
                    end
                end else if ((count_s < DEPTH_C) || pop_s) begin
                    push_s    = 1'b1;
                    pc_next_s = pc_r + 32'(INSTR_BYTES);
                end else begin
                    push_s = 1'b0;
                end
            end
            FETCH_HALT: begin
                state_next_s = FETCH_HALT;
            end
            default: begin
                state_next_s = FETCH_HALT;
                err_next_s   = 1'b1;
            end
        endcase
    end

    // Control state, PC and sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH_RUN;
            pc_r    <= RESET_PC;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            err_r   <= err_next_s;
        end
    end

    fetch_fifo2 u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .din   (din_s),
        .head  (head_s),
        .count (count_s)
    );

    assign imem_addr   = pc_r;
    assign instr_valid = (count_s != 2'd0);
    assign instr_out   = head_s.instr;
    assign pc_out      = head_s.pc;
    assign fetch_err   = err_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected {valid, pc, instr} entries are
// queued as stimulus is applied and popped as the fetch unit presents them.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_out, pc_out;
    logic        fetch_err;

    logic [31:0] imem_addr_w, imem_rdata_w, instr_out_w, pc_out_w;
    logic        instr_valid_w, fetch_err_w;

    int vectors     = 0;
    int miscompares = 0;
    logic [64:0] exp_q[$];
    logic [64:0] got, exp_v;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = {2'b00, a[31:2]};
        return (idx * 32'h9E37_79B9) ^ 32'h0F0F_1234;
    endfunction

    function automatic logic [64:0] ent(input logic [31:0] pc);
        return {1'b1, pc, rom_word(pc)};
    endfunction

    assign imem_rdata   = rom_word(imem_addr);
    assign imem_rdata_w = rom_word(imem_addr_w);

    instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .pc_out(pc_out), .fetch_err(fetch_err)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_w (
        .clk(clk), .reset(reset), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
        .redirect_valid(1'b0), .redirect_target(32'h0000_0000),
        .instr_valid(instr_valid_w), .instr_ready(1'b1),
        .instr_out(instr_out_w), .pc_out(pc_out_w), .fetch_err(fetch_err_w)
    );

    task automatic do_reset(input logic ready);
        @(negedge clk);
        reset = 1'b1;
        redirect_valid = 1'b0;
        instr_ready = ready;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({imem_addr, instr_valid, instr_out, pc_out, fetch_err} !== {32'h0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got addr=%h v=%b instr=%h pc=%h err=%b, expected all zero",
                     imem_addr, instr_valid, instr_out, pc_out, fetch_err);
        end
        vectors++;
        if (imem_addr_w !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL reset_pc_param: got %h expected fffffffc", imem_addr_w);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) exp_q.push_back(ent(32'(i * 4)));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got = {instr_valid, pc_out, instr_out};
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL stream[%0d]: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_addr;
        do_reset(1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp_addr = (k == 1) ? 32'h4 : 32'h8;
            vectors++;
            if ({imem_addr, instr_valid, pc_out} !== {exp_addr, 1'b1, 32'h0}) begin
                miscompares++;
                $display("FAIL hold[%0d]: got addr=%h v=%b pc=%h expected addr=%h v=1 pc=0",
                         k, imem_addr, instr_valid, pc_out, exp_addr);
            end
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(ent(32'(i * 4)));
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            got = {instr_valid, pc_out, instr_out};
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL drain[%0d]: got %h expected %h", i, got, exp_v);
            end
            instr_ready = 1'b1;
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_001C;
        @(negedge clk);
        redirect_valid = 1'b0;
        vectors++;
        if ({instr_valid, imem_addr} !== {1'b0, 32'h0000_001C}) begin
            miscompares++;
            $display("FAIL redirect_flush: got v=%b addr=%h expected v=0 addr=0000001c", instr_valid, imem_addr);
        end
        exp_q.push_back(ent(32'h1C));
        exp_q.push_back(ent(32'h20));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = {instr_valid, pc_out, instr_out};
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL redirect_head[%0d]: got %h expected %h", i, got, exp_v);
            end
            instr_ready = 1'b1;
        end
        // Redirect while a pop is also in progress.
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0040;
        @(negedge clk);
        redirect_valid = 1'b0;
        vectors++;
        if ({instr_valid, imem_addr} !== {1'b0, 32'h0000_0040}) begin
            miscompares++;
            $display("FAIL redirect_pop: got v=%b addr=%h expected v=0 addr=00000040", instr_valid, imem_addr);
        end
        exp_q.push_back(ent(32'h40));
        @(negedge clk);
        got = {instr_valid, pc_out, instr_out};
        exp_v = exp_q.pop_front();
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL redirect_pop_head: got %h expected %h", got, exp_v);
        end
    endtask

    task automatic test_misaligned();
        do_reset(1'b1);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_001E;
        @(negedge clk);
        redirect_target = 32'h0000_0020;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            vectors++;
            if ({fetch_err, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h4}) begin
                miscompares++;
                $display("FAIL halt[%0d]: got err=%b v=%b addr=%h expected err=1 v=0 addr=00000004",
                         i, fetch_err, instr_valid, imem_addr);
            end
        end
        redirect_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({fetch_err, imem_addr} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL err_clear: got err=%b addr=%h expected err=0 addr=0", fetch_err, imem_addr);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        exp_q.push_back(ent(32'hFFFF_FFFC));
        exp_q.push_back(ent(32'h0000_0000));
        exp_q.push_back(ent(32'h0000_0004));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = {instr_valid_w, pc_out_w, instr_out_w};
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        vectors++;
        if ({instr_valid, imem_addr} !== {1'b1, 32'h8}) begin
            miscompares++;
            $display("FAIL prefull: got v=%b addr=%h expected v=1 addr=00000008", instr_valid, imem_addr);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({instr_valid, imem_addr, pc_out, instr_out} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b addr=%h pc=%h instr=%h expected all zero",
                     instr_valid, imem_addr, pc_out, instr_out);
        end
        @(negedge clk);
        reset = 1'b0;
        instr_ready = 1'b1;
        exp_q.delete();
        exp_q.push_back(ent(32'h0));
        exp_q.push_back(ent(32'h4));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = {instr_valid, pc_out, instr_out};
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL post_reset[%0d]: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0000_0000;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
